cosim_commit_scheduler: RTL and testbench

- Sits between the core's per-hart commit ports and the single co-simulation checker interface (DPI commit/judge shim).
- Buffers up to COMMITS retirements per hart per cycle in per-hart FIFOs, preserving program order.
- Serialises the buffered retirements to one record per cycle, using round-robin arbitration across harts.
- Applies backpressure to the core and flags overflow.

---
 rtl/cosim_commit_scheduler.sv | 179 +++++++++++++++++
 tb/tb_cosim_commit_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_commit_scheduler.sv
// cosim_commit_scheduler
//   Collects up to COMMITS retirements per hart per cycle into per-hart FIFOs
//   (program order kept, invalid slots compacted away) and serialises them to a
//   single co-simulation checker port, one record per cycle, round-robin across
//   harts. Raises per-hart backpressure and a sticky overflow flag.
//
// Ports
//   clock, reset         clock; asynchronous active-low reset
//   in_valid/pc/insn/wen/waddr/wdata
//                        per-slot retirement, slot index h*COMMITS+s (slot 0 oldest)
//   in_ready             per hart: room for a full COMMITS-wide group
//   out_valid/out_ready  serialised record handshake
//   out_hartid/pc/insn/wen/waddr/wdata
//                        record fields, zero while out_valid is low
//   overflow             sticky: valid slot seen while that hart's in_ready was low
//   commit_count         records accepted since reset (wraps at 2^64)
module cosim_commit_scheduler #(
  parameter int unsigned HARTS   = 1,
  parameter int unsigned COMMITS = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [HARTS*COMMITS-1:0]                      in_valid,
  input  logic [HARTS*COMMITS*64-1:0]                   in_pc,
  input  logic [HARTS*COMMITS*32-1:0]                   in_insn,
  input  logic [HARTS*COMMITS-1:0]                      in_wen,
  input  logic [HARTS*COMMITS*5-1:0]                    in_waddr,
  input  logic [HARTS*COMMITS*64-1:0]                   in_wdata,
  output logic [HARTS-1:0]                              in_ready,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [((HARTS > 1) ? $clog2(HARTS) : 1)-1:0]  out_hartid,
  output logic [63:0]                                   out_pc,
  output logic [31:0]                                   out_insn,
  output logic                                          out_wen,
  output logic [4:0]                                    out_waddr,
  output logic [63:0]                                   out_wdata,
  output logic                                          overflow,
  output logic [63:0]                                   commit_count
);

  localparam int unsigned HW = (HARTS > 1) ? $clog2(HARTS) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NS = HARTS * COMMITS;

  // Storage (not reset; contents are only observable behind a non-zero count)
  logic [63:0] pc_mem    [HARTS][DEPTH];
  logic [31:0] insn_mem  [HARTS][DEPTH];
  logic        wen_mem   [HARTS][DEPTH];
  logic [4:0]  waddr_mem [HARTS][DEPTH];
  logic [63:0] wdata_mem [HARTS][DEPTH];

  logic [CW-1:0] count_q [HARTS];
  logic [CW-1:0] count_d [HARTS];
  logic [PW-1:0] wptr_q  [HARTS];
  logic [PW-1:0] rptr_q  [HARTS];

  logic [HW-1:0] rr_q;
  logic [HW-1:0] rr_d;
  logic          hold_q;
  logic [HW-1:0] hold_grant_q;

  logic [CW-1:0]    push_cnt [HARTS];
  logic [CW-1:0]    push_amt [HARTS];
  logic [PW-1:0]    wr_idx   [NS];
  logic [HARTS-1:0] hart_any;
  logic [HARTS-1:0] pop;
  logic [HARTS-1:0] cand;
  logic             overflow_set;
  logic [HW-1:0]    arb_grant;
  logic             arb_found;
  logic [HW-1:0]    grant;
  logic             accept;

  // Enqueue: each valid slot lands at wptr + (number of older valid slots).
  always_comb begin
    overflow_set = 1'b0;
    for (int h = 0; h < HARTS; h++) begin
      push_cnt[h] = '0;
      hart_any[h] = 1'b0;
      // Registered count only: a concurrent pop does not free space this cycle.
      in_ready[h] = (DEPTH - 32'(count_q[h])) >= COMMITS;
      for (int s = 0; s < COMMITS; s++) begin
        wr_idx[h*COMMITS+s] = wptr_q[h] + push_cnt[h][PW-1:0];
        if (in_valid[h*COMMITS+s]) begin
          push_cnt[h] = push_cnt[h] + CW'(1);
          hart_any[h] = 1'b1;
        end
      end
      push_amt[h] = in_ready[h] ? push_cnt[h] : '0;
      if (hart_any[h] && !in_ready[h]) overflow_set = 1'b1;
    end
  end

  // Arbitration: first non-empty hart at or after rr_q; a stalled grant is frozen.
  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    for (int h = 0; h < HARTS; h++) cand[h] = (count_q[h] != '0);
    for (int i = 0; i < HARTS; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % int'(HARTS);
      if (!arb_found && cand[idx]) begin
        arb_grant = HW'(idx);
        arb_found = 1'b1;
      end
    end
    grant     = hold_q ? hold_grant_q : arb_grant;
    out_valid = |cand;
    accept    = out_valid && out_ready;
    for (int h = 0; h < HARTS; h++) pop[h] = accept && (32'(grant) == h);
    rr_d = ((32'(grant) + 1) >= HARTS) ? '0 : grant + HW'(1);
    for (int h = 0; h < HARTS; h++) begin
      count_d[h] = count_q[h] + push_amt[h] - CW'(pop[h]);
    end
  end

  always_comb begin
    out_hartid = '0;
    out_pc     = '0;
    out_insn   = '0;
    out_wen    = 1'b0;
    out_waddr  = '0;
    out_wdata  = '0;
    if (out_valid) begin
      out_hartid = grant;
      out_pc     = pc_mem[grant][rptr_q[grant]];
      out_insn   = insn_mem[grant][rptr_q[grant]];
      out_wen    = wen_mem[grant][rptr_q[grant]];
      out_waddr  = waddr_mem[grant][rptr_q[grant]];
      out_wdata  = wdata_mem[grant][rptr_q[grant]];
    end
  end

  always_ff @(posedge clock) begin
    for (int h = 0; h < HARTS; h++) begin
      for (int s = 0; s < COMMITS; s++) begin
        if (in_valid[h*COMMITS+s] && in_ready[h]) begin
          pc_mem[h][wr_idx[h*COMMITS+s]]    <= in_pc[(h*COMMITS+s)*64 +: 64];
          insn_mem[h][wr_idx[h*COMMITS+s]]  <= in_insn[(h*COMMITS+s)*32 +: 32];
          wen_mem[h][wr_idx[h*COMMITS+s]]   <= in_wen[h*COMMITS+s];
          waddr_mem[h][wr_idx[h*COMMITS+s]] <= in_waddr[(h*COMMITS+s)*5 +: 5];
          wdata_mem[h][wr_idx[h*COMMITS+s]] <= in_wdata[(h*COMMITS+s)*64 +: 64];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int h = 0; h < HARTS; h++) begin
        count_q[h] <= '0;
        wptr_q[h]  <= '0;
        rptr_q[h]  <= '0;
      end
      rr_q         <= '0;
      hold_q       <= 1'b0;
      hold_grant_q <= '0;
      overflow     <= 1'b0;
      commit_count <= '0;
    end else begin
      for (int h = 0; h < HARTS; h++) begin
        count_q[h] <= count_d[h];
        wptr_q[h]  <= wptr_q[h] + push_amt[h][PW-1:0];
        rptr_q[h]  <= rptr_q[h] + PW'(pop[h]);
      end
      hold_q       <= out_valid && !out_ready;
      hold_grant_q <= grant;
      if (overflow_set) overflow <= 1'b1;
      if (accept) begin
        rr_q         <= rr_d;
        commit_count <= commit_count + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_cosim_commit_scheduler.sv
// Directed bench for cosim_commit_scheduler (HARTS=2, COMMITS=2, DEPTH=8).
module tb_cosim_commit_scheduler;

  localparam int unsigned HARTS   = 2;
  localparam int unsigned COMMITS = 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned NS      = HARTS * COMMITS;

  logic            clock = 1'b0;
  logic            reset;
  logic [NS-1:0]   in_valid;
  logic [NS*64-1:0] in_pc;
  logic [NS*32-1:0] in_insn;
  logic [NS-1:0]   in_wen;
  logic [NS*5-1:0] in_waddr;
  logic [NS*64-1:0] in_wdata;
  logic [HARTS-1:0] in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [0:0]      out_hartid;
  logic [63:0]     out_pc;
  logic [31:0]     out_insn;
  logic            out_wen;
  logic [4:0]      out_waddr;
  logic [63:0]     out_wdata;
  logic            overflow;
  logic [63:0]     commit_count;

  int vectors     = 0;
  int miscompares = 0;

  cosim_commit_scheduler #(
    .HARTS  (HARTS),
    .COMMITS(COMMITS),
    .DEPTH  (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_insn     (in_insn),
    .in_wen      (in_wen),
    .in_waddr    (in_waddr),
    .in_wdata    (in_wdata),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_hartid  (out_hartid),
    .out_pc      (out_pc),
    .out_insn    (out_insn),
    .out_wen     (out_wen),
    .out_waddr   (out_waddr),
    .out_wdata   (out_wdata),
    .overflow    (overflow),
    .commit_count(commit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_pc    = '0;
    in_insn  = '0;
    in_wen   = '0;
    in_waddr = '0;
    in_wdata = '0;
  endtask

  task automatic set_slot(input int idx, input logic [63:0] pc, input logic [31:0] insn,
                          input logic wen, input logic [4:0] waddr, input logic [63:0] wdata);
    in_valid[idx]          = 1'b1;
    in_pc[idx*64 +: 64]    = pc;
    in_insn[idx*32 +: 32]  = insn;
    in_wen[idx]            = wen;
    in_waddr[idx*5 +: 5]   = waddr;
    in_wdata[idx*64 +: 64] = wdata;
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b0;
    clear_in();
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_commit_count", commit_count, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd3);
    check("rst_out_pc_zero", out_pc, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Two slots, in order, no bypass
    out_ready = 1'b1;
    set_slot(0, 64'h8000_0000, 32'h0000_0013, 1'b1, 5'd1, 64'h11);
    set_slot(1, 64'h8000_0004, 32'h0010_0093, 1'b0, 5'd2, 64'h22);
    #1;
    check("no_bypass", 64'(out_valid), 64'd0);
    tick();
    clear_in();
    check("t1_valid0", 64'(out_valid), 64'd1);
    check("t1_pc0", out_pc, 64'h8000_0000);
    check("t1_insn0", 64'(out_insn), 64'h13);
    check("t1_wen0", 64'(out_wen), 64'd1);
    check("t1_waddr0", 64'(out_waddr), 64'd1);
    check("t1_wdata0", out_wdata, 64'h11);
    tick();
    check("t1_pc1", out_pc, 64'h8000_0004);
    check("t1_wen1", 64'(out_wen), 64'd0);
    check("t1_count1", commit_count, 64'd1);
    tick();
    check("t1_empty", 64'(out_valid), 64'd0);
    check("t1_count2", commit_count, 64'd2);

    // Compaction: only slot 1 valid
    set_slot(1, 64'h8000_0010, 32'h0000_0073, 1'b0, 5'd0, 64'h0);
    tick();
    clear_in();
    check("cmp_pc", out_pc, 64'h8000_0010);
    tick();
    check("cmp_empty", 64'(out_valid), 64'd0);
    check("cmp_count", commit_count, 64'd3);

    // Backpressure: fill hart 0 to 8, then overflow
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("bp_ready_before_push", 64'(in_ready[0]), 64'd1);
      set_slot(0, 64'h1000 + 64'(c * 8), 32'h1, 1'b0, 5'd0, 64'h0);
      set_slot(1, 64'h1004 + 64'(c * 8), 32'h1, 1'b0, 5'd0, 64'h0);
      tick();
      clear_in();
    end
    check("bp_ready_full", 64'(in_ready[0]), 64'd0);
    check("bp_no_overflow_yet", 64'(overflow), 64'd0);
    set_slot(0, 64'hdead, 32'h1, 1'b0, 5'd0, 64'h0);
    tick();
    clear_in();
    check("bp_overflow", 64'(overflow), 64'd1);

    // Stall hold
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_pc", out_pc, 64'h1000);
      check("hold_hartid", 64'(out_hartid), 64'd0);
      tick();
    end

    // Drain exactly 8 in order; the overflowed slot must be absent
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_pc", out_pc, 64'h1000 + 64'(i * 4));
      tick();
    end
    check("drain_empty", 64'(out_valid), 64'd0);
    check("drain_count", commit_count, 64'd11);
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Async reset with 4 entries buffered
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_slot(0, 64'h5000 + 64'(c * 8), 32'h1, 1'b0, 5'd0, 64'h0);
      set_slot(1, 64'h5004 + 64'(c * 8), 32'h1, 1'b0, 5'd0, 64'h0);
      tick();
      clear_in();
    end
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid_immediate", 64'(out_valid), 64'd0);
    check("ar_pc_zero", out_pc, 64'd0);
    tick();
    reset = 1'b1;
    check("ar_count", commit_count, 64'd0);
    check("ar_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("ar_no_stale", 64'(out_valid), 64'd0);
    end

    // Two harts, three entries each, RR interleave
    out_ready = 1'b0;
    set_slot(0, 64'h2000, 32'h1, 1'b0, 5'd0, 64'h0);
    set_slot(1, 64'h2004, 32'h1, 1'b0, 5'd0, 64'h0);
    set_slot(2, 64'h3000, 32'h1, 1'b0, 5'd0, 64'h0);
    set_slot(3, 64'h3004, 32'h1, 1'b0, 5'd0, 64'h0);
    tick();
    clear_in();
    set_slot(0, 64'h2008, 32'h1, 1'b0, 5'd0, 64'h0);
    set_slot(2, 64'h3008, 32'h1, 1'b0, 5'd0, 64'h0);
    tick();
    clear_in();
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      logic [63:0] exp_pc;
      exp_pc = ((i % 2) == 0 ? 64'h2000 : 64'h3000) + 64'((i / 2) * 4);
      check("rr_hartid", 64'(out_hartid), 64'(i % 2));
      check("rr_pc", out_pc, exp_pc);
      tick();
    end
    check("rr_empty", 64'(out_valid), 64'd0);
    check("rr_count", commit_count, 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
